// File: rtl/mii_rx_nibble_packer.sv
// mii_rx_nibble_packer
// Converts the 4-bit MII receive stream into a framed byte stream for the MAC.
// It strips the preamble and SFD, then pairs data nibbles low-first into bytes.
// It flags SOF on the first byte and pulses EOF with error and length after the frame.
//
// Optional feature: define MII_RX_STATS_EN to keep saturating good/bad frame counters.
//
// Ports:
//   clock          receive clock (PHY rx clock)
//   reset          synchronous, active-low reset
//   io_mii_rxd     MII receive nibble
//   io_mii_rx_dv   MII receive data valid
//   io_mii_rx_er   MII receive error
//   io_rx_data     assembled byte, qualified by io_rx_valid
//   io_rx_valid    one-cycle byte strobe
//   io_rx_sof      first byte of the frame (with io_rx_valid)
//   io_rx_eof      one-cycle end-of-frame strobe, never with io_rx_valid
//   io_rx_err      frame error, qualified by io_rx_eof
//   io_rx_len      bytes emitted for the frame, qualified by io_rx_eof
//   io_stat_good   frames ended without error (0 unless MII_RX_STATS_EN)
//   io_stat_bad    frames ended with error (0 unless MII_RX_STATS_EN)
module mii_rx_nibble_packer #(
  parameter int unsigned MAX_BYTES = 1522,
  parameter int unsigned LEN_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       io_mii_rxd,
  input  logic             io_mii_rx_dv,
  input  logic             io_mii_rx_er,
  output logic [7:0]       io_rx_data,
  output logic             io_rx_valid,
  output logic             io_rx_sof,
  output logic             io_rx_eof,
  output logic             io_rx_err,
  output logic [LEN_W-1:0] io_rx_len,
  output logic [31:0]      io_stat_good,
  output logic [31:0]      io_stat_bad
);

  typedef enum logic [1:0] {StIdle, StPreamble, StData, StDrop} state_e;

  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_BYTES);

  // Frame-tracking state
  state_e           r_state, w_state_d;
  logic             r_armed, w_armed_d;
  logic [LEN_W-1:0] r_len, w_len_d;
  logic             r_err, w_err_d;
  logic             r_phase, w_phase_d;
  logic [3:0]       r_lo, w_lo_d;
  logic             r_first, w_first_d;

  // First pipeline stage: events decided at the sampling edge
  logic             r_byte_vld, w_byte_vld_d;
  logic [7:0]       r_byte, w_byte_d;
  logic             r_byte_sof, w_byte_sof_d;
  logic             r_end, w_end_d;
  logic             r_end_err, w_end_err_d;
  logic [LEN_W-1:0] r_end_len, w_end_len_d;

  // Output stage: events appear one edge after they were decided
  logic             r_rx_valid;
  logic [7:0]       r_rx_data;
  logic             r_rx_sof;
  logic             r_rx_eof;
  logic             r_rx_err;
  logic [LEN_W-1:0] r_rx_len;

  always_comb begin
    w_state_d    = r_state;
    // Arm only after a quiet cycle so a reset released mid-frame is ignored.
    w_armed_d    = r_armed | ~io_mii_rx_dv;
    w_len_d      = r_len;
    w_err_d      = r_err;
    w_phase_d    = r_phase;
    w_lo_d       = r_lo;
    w_first_d    = r_first;
    w_byte_vld_d = 1'b0;
    w_byte_d     = 8'h00;
    w_byte_sof_d = 1'b0;
    w_end_d      = 1'b0;
    w_end_err_d  = 1'b0;
    w_end_len_d  = '0;

    unique case (r_state)
      StIdle: begin
        if (io_mii_rx_dv && r_armed) begin
          w_state_d = (io_mii_rxd == 4'h5) ? StPreamble : StDrop;
        end
      end
      StPreamble: begin
        if (!io_mii_rx_dv) begin
          w_state_d = StIdle;
        end else if (io_mii_rxd == 4'h5) begin
          w_state_d = StPreamble;
        end else if (io_mii_rxd == 4'hD) begin
          w_state_d = StData;
          w_len_d   = '0;
          w_err_d   = 1'b0;
          w_phase_d = 1'b0;
          w_first_d = 1'b1;
        end else begin
          w_state_d = StDrop;
        end
      end
      StData: begin
        if (io_mii_rx_dv) begin
          w_phase_d = ~r_phase;
          if (!r_phase) begin
            w_lo_d = io_mii_rxd;
          end else if (r_len < MaxLen) begin
            w_byte_vld_d = 1'b1;
            w_byte_d     = {io_mii_rxd, r_lo};
            w_byte_sof_d = r_first;
            w_first_d    = 1'b0;
            w_len_d      = r_len + LEN_W'(1);
          end else begin
            w_err_d = 1'b1;
          end
          if (io_mii_rx_er) begin
            w_err_d = 1'b1;
          end
        end else begin
          // A pending low nibble at frame end is a dribble nibble.
          w_end_d     = 1'b1;
          w_end_err_d = r_err | r_phase | io_mii_rx_er;
          w_end_len_d = r_len;
          w_state_d   = StIdle;
        end
      end
      StDrop: begin
        if (!io_mii_rx_dv) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_armed    <= 1'b0;
      r_len      <= '0;
      r_err      <= 1'b0;
      r_phase    <= 1'b0;
      r_lo       <= 4'h0;
      r_first    <= 1'b0;
      r_byte_vld <= 1'b0;
      r_byte     <= 8'h00;
      r_byte_sof <= 1'b0;
      r_end      <= 1'b0;
      r_end_err  <= 1'b0;
      r_end_len  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= 8'h00;
      r_rx_sof   <= 1'b0;
      r_rx_eof   <= 1'b0;
      r_rx_err   <= 1'b0;
      r_rx_len   <= '0;
    end else begin
      r_state    <= w_state_d;
      r_armed    <= w_armed_d;
      r_len      <= w_len_d;
      r_err      <= w_err_d;
      r_phase    <= w_phase_d;
      r_lo       <= w_lo_d;
      r_first    <= w_first_d;
      r_byte_vld <= w_byte_vld_d;
      r_byte     <= w_byte_d;
      r_byte_sof <= w_byte_sof_d;
      r_end      <= w_end_d;
      r_end_err  <= w_end_err_d;
      r_end_len  <= w_end_len_d;
      r_rx_valid <= r_byte_vld;
      r_rx_data  <= r_byte;
      r_rx_sof   <= r_byte_sof;
      r_rx_eof   <= r_end;
      r_rx_err   <= r_end_err;
      r_rx_len   <= r_end_len;
    end
  end

  assign io_rx_valid = r_rx_valid;
  assign io_rx_data  = r_rx_data;
  assign io_rx_sof   = r_rx_sof;
  assign io_rx_eof   = r_rx_eof;
  assign io_rx_err   = r_rx_err;
  assign io_rx_len   = r_rx_len;

`ifdef MII_RX_STATS_EN
  logic [31:0] r_stat_good;
  logic [31:0] r_stat_bad;

  // Counters follow the EOF strobe and saturate instead of wrapping.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_stat_good <= 32'h0;
      r_stat_bad  <= 32'h0;
    end else if (r_rx_eof) begin
      if (r_rx_err) begin
        if (r_stat_bad != 32'hFFFF_FFFF) r_stat_bad <= r_stat_bad + 32'd1;
      end else begin
        if (r_stat_good != 32'hFFFF_FFFF) r_stat_good <= r_stat_good + 32'd1;
      end
    end
  end

  assign io_stat_good = r_stat_good;
  assign io_stat_bad  = r_stat_bad;
`else
  assign io_stat_good = 32'h0;
  assign io_stat_bad  = 32'h0;
`endif

endmodule
